// File: rtl/vector_load_buffer_pkg.sv
// Shared definitions for the vector load buffer: default sizes shared with
// multiplierCell, state encodings and the index-width helper.
package vector_load_buffer_pkg;

    localparam int VLB_DEFAULT_MATRIXSIZE = 5;
    localparam int VLB_DEFAULT_DATA_W     = 8;

    typedef enum logic [1:0] {
        VLB_LOAD_A  = 2'd0,
        VLB_LOAD_B  = 2'd1,
        VLB_PRESENT = 2'd2
    } vlb_state_t;

    // Width of an index covering 0..n-1, never narrower than one bit.
    function automatic int vlb_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vector_load_buffer_timeout_counter.sv
// Idle counter for vector_load_buffer: counts enabled cycles and raises a
// terminal pulse on the last one; clear or terminal returns it to zero.
module vlb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic terminal
);

    localparam int CNT_W = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    assign terminal = enable & (count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || terminal) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vector_load_buffer.sv
// Assembles serial elements into an A and a B vector and presents them as a
// pair until acknowledged. Optional partial-load abort under VLB_TIMEOUT_EN.
module vector_load_buffer
    import vector_load_buffer_pkg::*;
#(
    parameter int MATRIXSIZE     = VLB_DEFAULT_MATRIXSIZE,
    parameter int DATA_W         = VLB_DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [MATRIXSIZE*DATA_W-1:0] a_flat,
    output logic [MATRIXSIZE*DATA_W-1:0] b_flat,
    output logic                         vec_valid,
    input  logic                         vec_ready,
    output logic                         busy,
    output logic                         timeout_flag
);

    localparam int IDX_W = vlb_idx_width(MATRIXSIZE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MATRIXSIZE - 1);

    vlb_state_t       state;
    logic [IDX_W-1:0] idx;
    logic             xfer;
    logic             last_slot;
    logic             abort;

    // in_ready is gated by rst so the host sees no acceptance during reset.
    assign in_ready  = ~rst & (state != VLB_PRESENT);
    assign vec_valid = (state == VLB_PRESENT);
    assign busy      = (state == VLB_LOAD_B) | ((state == VLB_LOAD_A) & (idx != '0));
    assign xfer      = in_valid & in_ready;
    assign last_slot = (idx == IDX_LAST);

`ifdef VLB_TIMEOUT_EN
    logic idle_tick;

    assign idle_tick = busy & ~xfer;

    vlb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (idle_tick),
        .clear   (~idle_tick),
        .terminal(abort)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_flag <= 1'b0;
        end else begin
            timeout_flag <= abort;
        end
    end
`else
    assign abort        = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // Slots are overwritten in place; stale data from earlier loads is only
    // visible while vec_valid is low, where it carries no meaning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= VLB_LOAD_A;
            idx    <= '0;
            a_flat <= '0;
            b_flat <= '0;
        end else if (abort) begin
            state <= VLB_LOAD_A;
            idx   <= '0;
        end else begin
            case (state)
                VLB_LOAD_A: begin
                    if (xfer) begin
                        a_flat[int'(idx)*DATA_W +: DATA_W] <= in_data;
                        if (last_slot) begin
                            idx   <= '0;
                            state <= VLB_LOAD_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                VLB_LOAD_B: begin
                    if (xfer) begin
                        b_flat[int'(idx)*DATA_W +: DATA_W] <= in_data;
                        if (last_slot) begin
                            idx   <= '0;
                            state <= VLB_PRESENT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                VLB_PRESENT: begin
                    if (vec_ready) begin
                        idx   <= '0;
                        state <= VLB_LOAD_A;
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= VLB_LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_load_buffer.sv
// Self-checking bench for vector_load_buffer: directed test-plan steps then
// randomized vector pairs checked against a queue-free packing model.
module tb_vector_load_buffer;

    localparam int MS = 5;
    localparam int DW = 8;
    localparam int TO = 16;

    typedef logic [DW-1:0] vec_t [MS];

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DW-1:0]    in_data = '0;
    logic             in_valid = 1'b0;
    logic             vec_ready = 1'b0;
    logic             in_ready;
    logic [MS*DW-1:0] a_flat;
    logic [MS*DW-1:0] b_flat;
    logic             vec_valid;
    logic             busy;
    logic             timeout_flag;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vector_load_buffer #(
        .MATRIXSIZE    (MS),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_flat      (a_flat),
        .b_flat      (b_flat),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready),
        .busy        (busy),
        .timeout_flag(timeout_flag)
    );

    // Reference packing: element i occupies bits [i*DW +: DW].
    function automatic logic [MS*DW-1:0] pack(input vec_t e);
        logic [MS*DW-1:0] r = '0;
        for (int i = 0; i < MS; i++) r = r | ((MS*DW)'(e[i]) << (i*DW));
        return r;
    endfunction

    function automatic int dot(input logic [MS*DW-1:0] a, input logic [MS*DW-1:0] b);
        int s = 0;
        for (int i = 0; i < MS; i++) s += int'(a[i*DW +: DW]) * int'(b[i*DW +: DW]);
        return s;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one element and return #1 after the edge that accepts it.
    task automatic apply_stimulus(input logic [DW-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("in_ready_wait", 64'(n < 50), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_pair(input vec_t a, input vec_t b, input int gap);
        for (int i = 0; i < 2*MS; i++) begin
            apply_stimulus(i < MS ? a[i] : b[i-MS]);
            if (i < 2*MS-1) begin
                check_output("busy_load", 64'(busy), 64'd1);
                check_output("vec_valid_early", 64'(vec_valid), 64'd0);
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    check_output("busy_gap", 64'(busy), 64'd1);
                end
            end
        end
        check_output("vec_valid_rise", 64'(vec_valid), 64'd1);
        check_output("busy_present", 64'(busy), 64'd0);
    endtask

    task automatic accept_pair(input vec_t a, input vec_t b, input int delay);
        check_output("a_flat", 64'(a_flat), 64'(pack(a)));
        check_output("b_flat", 64'(b_flat), 64'(pack(b)));
        check_output("in_ready_present", 64'(in_ready), 64'd0);
        check_output("timeout_idle", 64'(timeout_flag), 64'd0);
        for (int d = 0; d < delay; d++) begin
            @(posedge clk); #1;
            check_output("vec_valid_hold", 64'(vec_valid), 64'd1);
        end
        vec_ready = 1'b1;
        @(posedge clk); #1;
        vec_ready = 1'b0;
        check_output("vec_valid_fall", 64'(vec_valid), 64'd0);
        check_output("in_ready_return", 64'(in_ready), 64'd1);
    endtask

    initial begin
        vec_t basic_a = '{8'd4, 8'd6, 8'd8, 8'd4, 8'd2};
        vec_t basic_b = '{8'd3, 8'd9, 8'd1, 8'd5, 8'd1};
        vec_t ones    = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        vec_t twos    = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
        vec_t ra;
        vec_t rb;
        logic [MS*DW-1:0] held_a;
        logic [MS*DW-1:0] held_b;

        #12;
        check_output("rst_in_ready", 64'(in_ready), 64'd0);
        check_output("rst_vec_valid", 64'(vec_valid), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_a_flat", 64'(a_flat), 64'd0);
        check_output("rst_b_flat", 64'(b_flat), 64'd0);
        check_output("rst_timeout", 64'(timeout_flag), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_output("idle_in_ready", 64'(in_ready), 64'd1);

        // Basic load, then hold in PRESENT against in_valid pressure.
        load_pair(basic_a, basic_b, 0);
        check_output("basic_a_const", 64'(a_flat), 64'h0204080604);
        check_output("basic_b_const", 64'(b_flat), 64'h0105010903);
        check_output("basic_dot", 64'(dot(a_flat, b_flat)), 64'd96);
        held_a   = a_flat;
        held_b   = b_flat;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_output("hold_in_ready", 64'(in_ready), 64'd0);
            check_output("hold_a_flat", 64'(a_flat), 64'(held_a));
            check_output("hold_b_flat", 64'(b_flat), 64'(held_b));
        end
        in_valid = 1'b0;
        accept_pair(basic_a, basic_b, 0);

        load_pair(ones, twos, 0);
        accept_pair(ones, twos, 0);

        load_pair(basic_a, basic_b, 3);
        accept_pair(basic_a, basic_b, 1);

        // Asynchronous reset between edges during a partial A load.
        for (int i = 0; i < 3; i++) apply_stimulus(twos[i] + 8'd7);
        #2 rst = 1'b1;
        #1;
        check_output("mid_rst_a_flat", 64'(a_flat), 64'd0);
        check_output("mid_rst_b_flat", 64'(b_flat), 64'd0);
        check_output("mid_rst_busy", 64'(busy), 64'd0);
        check_output("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check_output("mid_rst_vec_valid", 64'(vec_valid), 64'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        load_pair(basic_a, basic_b, 0);
        accept_pair(basic_a, basic_b, 0);

`ifdef VLB_TIMEOUT_EN
        apply_stimulus(8'h11);
        apply_stimulus(8'h22);
        for (int k = 1; k <= TO; k++) begin
            @(posedge clk); #1;
            if (k == TO-1) check_output("to_not_yet", 64'(timeout_flag), 64'd0);
            if (k == TO) begin
                check_output("to_pulse", 64'(timeout_flag), 64'd1);
                check_output("to_busy", 64'(busy), 64'd0);
            end
        end
        @(posedge clk); #1;
        check_output("to_single_pulse", 64'(timeout_flag), 64'd0);

        ra = '{8'h44, 8'h55, 8'h33, 8'h66, 8'h77};
        rb = '{8'h81, 8'h92, 8'hA3, 8'hB4, 8'hC5};
        apply_stimulus(ra[0]);
        apply_stimulus(ra[1]);
        for (int k = 1; k < TO; k++) begin
            @(posedge clk); #1;
        end
        apply_stimulus(ra[2]);
        check_output("to_saved_flag", 64'(timeout_flag), 64'd0);
        check_output("to_saved_busy", 64'(busy), 64'd1);
        for (int i = 3; i < 2*MS; i++) apply_stimulus(i < MS ? ra[i] : rb[i-MS]);
        check_output("to_saved_valid", 64'(vec_valid), 64'd1);
        accept_pair(ra, rb, 0);
`endif

        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < MS; i++) begin
                ra[i] = DW'($urandom);
                rb[i] = DW'($urandom);
            end
            load_pair(ra, rb, int'($urandom_range(0, 2)));
            accept_pair(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
